// File: rtl/quad_decoder.sv
// quad_decoder: quadrature encoder front end.
// Each raw channel is synchronised and glitch-filtered. The filtered {A,B} pair
// is then decoded as a Gray sequence into a one-cycle step strobe, a direction
// level and a one-cycle error strobe for illegal two-bit jumps.
module quad_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enIn,
  input  logic       quadA,
  input  logic       quadB,
  output logic       stepOut,
  output logic       dirOut,
  output logic       errOut,
  output logic [1:0] stateOut
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  // Bit 1 carries channel A and bit 0 carries channel B, matching {A_f, B_f}.
  logic [1:0] raw;
  logic [1:0] filt_p1;
  logic [1:0] prev_p2;
  logic [1:0] delta;

  assign raw = {quadA, quadB};

  // Position of a state along the up sequence 00->01->11->10 (Gray to binary).
  function automatic logic [1:0] gray_pos(input logic [1:0] s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  // Next filter count: clear when the levels agree or on commit, otherwise count.
  function automatic logic [CNT_W-1:0] filter_cnt_next(input logic s, input logic f,
                                                       input logic [CNT_W-1:0] cnt);
    if (s == f || cnt == CNT_LAST) return '0;
    return cnt + 1'b1;
  endfunction

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   lvl_s;
    logic [CNT_W-1:0]       cnt_p1;
    logic                   lvl_f_p1;

    assign lvl_s       = sync_p0[SYNC_STAGES-1];
    assign filt_p1[ch] = lvl_f_p1;

    // Stage 0: synchroniser chain for the asynchronous raw channel.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_p0 <= '0;
      else        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw[ch]};
    end

    // Stage 1: accept a new level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_p1   <= '0;
        lvl_f_p1 <= 1'b0;
      end else begin
        cnt_p1 <= filter_cnt_next(lvl_s, lvl_f_p1, cnt_p1);
        if (lvl_s != lvl_f_p1 && cnt_p1 == CNT_LAST) lvl_f_p1 <= lvl_s;
      end
    end
  end

  assign stateOut = filt_p1;

  // Distance travelled along the up sequence: 1 = up, 3 = down, 2 = illegal jump.
  assign delta = gray_pos(filt_p1) - gray_pos(prev_p2);

  // Stage 2: decode previous vs current filtered state into registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_p2 <= 2'b00;
      stepOut <= 1'b0;
      errOut  <= 1'b0;
      dirOut  <= 1'b1;
    end else begin
      // Previous state always tracks, so re-enabling never sees a stale jump.
      prev_p2 <= filt_p1;
      stepOut <= 1'b0;
      errOut  <= 1'b0;
      if (enIn) begin
        case (delta)
          2'b01: begin
            stepOut <= 1'b1;
            dirOut  <= 1'b1;
          end
          2'b11: begin
            stepOut <= 1'b1;
            dirOut  <= 1'b0;
          end
          2'b10:   errOut <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed and randomised stimulus checked every cycle against
// a history-based reference model of the synchroniser, filter and decoder.
module tb_quad_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enIn = 1'b0;
  logic       quadA = 1'b0;
  logic       quadB = 1'b0;
  logic       stepOut, dirOut, errOut;
  logic [1:0] stateOut;

  int n_checks = 0;
  int n_fail   = 0;
  int step_cnt = 0;
  int err_cnt  = 0;
  int cyc      = 0;
  int first_step = -1;

  quad_decoder #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .enIn(enIn), .quadA(quadA), .quadB(quadB),
    .stepOut(stepOut), .dirOut(dirOut), .errOut(errOut), .stateOut(stateOut)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples delayed SYNC_STAGES edges, a filtered level that
  // flips once the last FILTER_LEN synchronised samples all disagree with it, and
  // a decoder that locates states in the up sequence by search.
  bit        sq_a[$], sq_b[$];
  bit        fh_a[$], fh_b[$];
  bit        m_af, m_bf, m_step, m_err, m_dir;
  bit [1:0]  m_prev, m_cur;
  int        m_d;

  function automatic int seq_idx(input bit [1:0] s);
    bit [1:0] up_seq [4];
    up_seq = '{2'b00, 2'b01, 2'b11, 2'b10};
    for (int i = 0; i < 4; i++) if (up_seq[i] == s) return i;
    return 0;
  endfunction

  function automatic bit all_differ(input bit q[$], input bit f);
    foreach (q[i]) if (q[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_a = {}; sq_b = {}; fh_a = {}; fh_b = {};
      for (int i = 0; i < SYNC_STAGES; i++) begin sq_a.push_back(1'b0); sq_b.push_back(1'b0); end
      for (int i = 0; i < FILTER_LEN; i++)  begin fh_a.push_back(1'b0); fh_b.push_back(1'b0); end
      m_af = 0; m_bf = 0; m_prev = 2'b00; m_step = 0; m_err = 0; m_dir = 1;
    end else begin
      m_cur  = {m_af, m_bf};
      m_d    = (seq_idx(m_cur) - seq_idx(m_prev) + 4) % 4;
      m_step = 0;
      m_err  = 0;
      if (enIn) begin
        if (m_d == 1)      begin m_step = 1; m_dir = 1; end
        else if (m_d == 3) begin m_step = 1; m_dir = 0; end
        else if (m_d == 2) m_err = 1;
      end
      m_prev = m_cur;
      fh_a.push_back(sq_a[0]); void'(fh_a.pop_front());
      fh_b.push_back(sq_b[0]); void'(fh_b.pop_front());
      if (all_differ(fh_a, m_af)) m_af = ~m_af;
      if (all_differ(fh_b, m_bf)) m_bf = ~m_bf;
      sq_a.push_back(quadA); void'(sq_a.pop_front());
      sq_b.push_back(quadB); void'(sq_b.pop_front());
    end
  end

  task automatic check_model(input string tag);
    n_checks += 4;
    assert (stepOut === m_step) else begin n_fail++; $error("FAIL %s stepOut observed=%b expected=%b", tag, stepOut, m_step); end
    assert (errOut === m_err) else begin n_fail++; $error("FAIL %s errOut observed=%b expected=%b", tag, errOut, m_err); end
    assert (dirOut === m_dir) else begin n_fail++; $error("FAIL %s dirOut observed=%b expected=%b", tag, dirOut, m_dir); end
    assert (stateOut === {m_af, m_bf}) else begin n_fail++; $error("FAIL %s stateOut observed=%b expected=%b", tag, stateOut, {m_af, m_bf}); end
  endtask

  task automatic check_int(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected) else begin n_fail++; $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected); end
  endtask

  task automatic tick(input string tag);
    @(posedge clk); #1;
    cyc++;
    if (stepOut === 1'b1) begin
      step_cnt++;
      if (first_step < 0) first_step = cyc;
    end
    if (errOut === 1'b1) err_cnt++;
    check_model(tag);
  endtask

  task automatic hold(input bit a, input bit b, input int n, input string tag);
    quadA = a; quadB = b;
    repeat (n) tick(tag);
  endtask

  task automatic clear_counts();
    step_cnt = 0; err_cnt = 0; cyc = 0; first_step = -1;
  endtask

  initial begin
    // Reset held while the channels toggle.
    for (int i = 0; i < 6; i++) begin
      quadA = i[0]; quadB = i[1];
      tick("reset_hold");
    end
    check_int("reset_step", int'(stepOut), 0);
    check_int("reset_dir", int'(dirOut), 1);
    check_int("reset_state", int'(stateOut), 0);

    // Release reset with inputs idle.
    quadA = 0; quadB = 0; rst_n = 1'b1;
    clear_counts();
    hold(0, 0, 10, "idle");
    check_int("idle_steps", step_cnt, 0);

    // Forward rotation.
    enIn = 1'b1;
    clear_counts();
    hold(0, 1, 10, "fwd_01");
    hold(1, 1, 10, "fwd_11");
    hold(1, 0, 10, "fwd_10");
    hold(0, 0, 10, "fwd_00");
    check_int("fwd_steps", step_cnt, 4);
    check_int("fwd_latency", first_step, SYNC_STAGES + FILTER_LEN + 1);
    check_int("fwd_dir", int'(dirOut), 1);

    // Reverse rotation.
    clear_counts();
    hold(1, 0, 10, "rev_10");
    hold(1, 1, 10, "rev_11");
    hold(0, 1, 10, "rev_01");
    hold(0, 0, 10, "rev_00");
    check_int("rev_steps", step_cnt, 4);
    check_int("rev_dir_after", int'(dirOut), 0);

    // Glitch shorter than the filter, then one just long enough.
    clear_counts();
    hold(1, 0, FILTER_LEN - 1, "glitch_short");
    hold(0, 0, 12, "glitch_short_tail");
    check_int("glitch_short_steps", step_cnt + err_cnt, 0);
    clear_counts();
    hold(1, 0, FILTER_LEN, "glitch_long");
    hold(0, 0, 12, "glitch_long_tail");
    check_int("glitch_long_steps", step_cnt, 2);

    // Illegal two-bit jump, then a legal up step.
    clear_counts();
    hold(1, 1, 12, "illegal_11");
    check_int("illegal_errs", err_cnt, 1);
    check_int("illegal_steps", step_cnt, 0);
    check_int("illegal_dir", int'(dirOut), 1);
    clear_counts();
    hold(1, 0, 12, "after_err_10");
    check_int("after_err_steps", step_cnt, 1);
    check_int("after_err_dir", int'(dirOut), 1);
    hold(0, 0, 12, "back_00");

    // Disabled decode keeps tracking; re-enable produces nothing.
    enIn = 1'b0;
    clear_counts();
    hold(0, 1, 12, "dis_01");
    check_int("dis_state", int'(stateOut), 1);
    enIn = 1'b1;
    hold(0, 1, 12, "reen_01");
    check_int("dis_reen_pulses", step_cnt + err_cnt, 0);

    // Randomised rotation, jitter, glitches and enable toggles.
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(9) == 0) enIn = ~enIn;
      hold(1'($urandom), 1'($urandom), int'($urandom_range(8, 1)), "random");
    end
    enIn = 1'b1;

    // Reset asserted mid-filter, between clock edges.
    hold(0, 0, 12, "pre_mid_rst");
    hold(1, 1, SYNC_STAGES + 2, "mid_filter");
    #2 rst_n = 1'b0;
    #1;
    check_model("async_rst");
    check_int("async_rst_step", int'(stepOut), 0);
    check_int("async_rst_dir", int'(dirOut), 1);
    check_int("async_rst_state", int'(stateOut), 0);
    tick("rst_low");
    quadA = 0; quadB = 0; rst_n = 1'b1;
    clear_counts();
    hold(0, 0, 10, "post_rst");
    check_int("post_rst_pulses", step_cnt + err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
